lvds_frame_sync: RTL and testbench

- Sits directly downstream of LVDS_capture. Consumes its 16-bit deserialised word stream on the capture clock.
- Searches for a periodic sync word and locks onto the frame structure. Then forwards payload words with start/end-of-frame tags through a small output FIFO using a valid/ready handshake.
- Reports lock status and counts payload words dropped on FIFO overflow.

---
 rtl/lvds_pkg.sv | 27 ++
 rtl/lvds_sync_fifo.sv | 62 ++++++
 rtl/lvds_frame_sync.sv | 169 ++++++++++++++++
 tb/tb_lvds_frame_sync.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_pkg.sv
// Shared types and defaults for the LVDS frame synchroniser.
// The FIFO entry struct describes one forwarded payload word with its
// frame-boundary tags; the top level packs the same fields by concatenation
// so that DATA_W can still be overridden per instance.
package lvds_pkg;

  // Default word width, matching the LVDS_capture final_output width
  localparam int LVDS_DATA_W = 16;

  // Default frame marker
  localparam logic [15:0] LVDS_SYNC_WORD = 16'hA5A5;

  // Frame alignment state machine
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } fsm_state_t;

  // One payload word as it sits in the output FIFO
  typedef struct packed {
    logic [LVDS_DATA_W-1:0] data;
    logic                   sof;
    logic                   eof;
  } fifo_entry_t;

endpackage

// File: rtl/lvds_sync_fifo.sv
// Small synchronous FIFO holding tagged payload words for the frame sync.
// A pop only happens when there is a head word; a push is accepted when there
// is room or when a pop frees a slot in the same cycle. The head outputs read
// zero while empty so the consumer never sees a stale word after a drain.
module lvds_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop_fire;
  logic             push_fire;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop_fire  = pop & ~empty;
  assign push_fire = push & (~full | pop_fire);
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_fire, pop_fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the empty flag masks whatever it holds
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/lvds_frame_sync.sv
// Frame synchroniser for the LVDS_capture word stream.
// Hunts for a periodic sync word, confirms the spacing over several frames,
// then forwards payload words tagged with start/end-of-frame through a small
// FIFO. Lock is dropped after consecutive missed syncs; a single miss is
// tolerated and the slot is still treated as the frame boundary.
module lvds_frame_sync
  import lvds_pkg::*;
#(
  parameter int                DATA_W     = LVDS_DATA_W,
  parameter logic [DATA_W-1:0] SYNC_WORD  = LVDS_SYNC_WORD,
  parameter int                FRAME_LEN  = 8,
  parameter int                LOCK_CNT   = 3,
  parameter int                LOSS_CNT   = 2,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk_out,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic [7:0]        overflow_cnt
);

  localparam int POS_W  = $clog2(FRAME_LEN + 1);
  localparam int HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);
  localparam int ENTRY_W = DATA_W + 2;

  fsm_state_t        state, state_n;
  logic [POS_W-1:0]  pos, pos_n, pos_adv;
  logic [HIT_W-1:0]  hit, hit_n;
  logic [MISS_W-1:0] miss, miss_n;

  logic               push;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               drop;
  logic               is_sync;

  assign is_sync = (in_data == SYNC_WORD);
  assign pos_adv = (pos == POS_W'(FRAME_LEN)) ? '0 : pos + POS_W'(1);

  // State, frame position and hit/miss counters advance only on valid words
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state <= SEARCH;
      pos   <= '0;
      hit   <= '0;
      miss  <= '0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      hit   <= hit_n;
      miss  <= miss_n;
    end
  end

  // Next-state logic: sync search, spacing verification and locked forwarding
  always_comb begin
    state_n    = state;
    pos_n      = pos;
    hit_n      = hit;
    miss_n     = miss;
    push       = 1'b0;
    push_entry = '0;
    if (in_valid) begin
      case (state)
        SEARCH: begin
          if (is_sync) begin
            pos_n = POS_W'(1);
            hit_n = HIT_W'(1);
            if (LOCK_CNT == 1) begin
              state_n = LOCKED;
              miss_n  = '0;
            end else begin
              state_n = VERIFY;
            end
          end else begin
            pos_n = '0;
          end
        end
        VERIFY: begin
          if (pos == '0) begin
            if (is_sync) begin
              pos_n = POS_W'(1);
              if (hit == HIT_W'(LOCK_CNT - 1)) begin
                state_n = LOCKED;
                hit_n   = HIT_W'(LOCK_CNT);
                miss_n  = '0;
              end else begin
                hit_n = hit + HIT_W'(1);
              end
            end else begin
              state_n = SEARCH;
              hit_n   = '0;
              pos_n   = '0;
            end
          end else begin
            pos_n = pos_adv;
          end
        end
        LOCKED: begin
          if (pos == '0) begin
            if (is_sync) begin
              miss_n = '0;
              pos_n  = POS_W'(1);
            end else if (miss == MISS_W'(LOSS_CNT - 1)) begin
              state_n = SEARCH;
              pos_n   = '0;
              hit_n   = '0;
              miss_n  = '0;
            end else begin
              miss_n = miss + MISS_W'(1);
              pos_n  = POS_W'(1);
            end
          end else begin
            push       = 1'b1;
            push_entry = {in_data, (pos == POS_W'(1)), (pos == POS_W'(FRAME_LEN))};
            pos_n      = pos_adv;
          end
        end
        default: begin
          state_n = SEARCH;
          pos_n   = '0;
          hit_n   = '0;
          miss_n  = '0;
        end
      endcase
    end
  end

  assign locked    = (state == LOCKED);
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign drop      = push & fifo_full & ~pop;
  assign {out_data, out_sof, out_eof} = head_entry;

  lvds_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk_out),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Count payload words lost to a full FIFO, holding at the top value
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      overflow_cnt <= '0;
    end else if (drop && (overflow_cnt != 8'hFF)) begin
      overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_lvds_frame_sync.sv
// Randomised bench for lvds_frame_sync with a word-indexed reference model.
// Frame slots are derived from the word index relative to the sync that
// started the current alignment; the output FIFO is modelled as a queue.
module tb_lvds_frame_sync;
  import lvds_pkg::*;

  localparam int FRAME_LEN = 8;
  localparam int LOCK_CNT  = 3;
  localparam int LOSS_CNT  = 2;
  localparam int DEPTH     = 4;
  localparam logic [15:0] SYNC = 16'hA5A5;
  localparam logic [15:0] BAD  = 16'h1234;

  logic        clk_out = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic [15:0] out_data;
  logic        out_sof;
  logic        out_eof;
  logic        out_valid;
  logic        out_ready;
  logic        locked;
  logic [7:0]  overflow_cnt;

  int checks = 0;
  int passes = 0;

  fsm_state_t  m_state;
  int          m_idx, m_anchor, m_goods, m_misses, m_ovf;
  fifo_entry_t m_q[$];

  always #5 clk_out = ~clk_out;

  lvds_frame_sync #(
    .DATA_W     (16),
    .SYNC_WORD  (SYNC),
    .FRAME_LEN  (FRAME_LEN),
    .LOCK_CNT   (LOCK_CNT),
    .LOSS_CNT   (LOSS_CNT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_out      (clk_out),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_sof      (out_sof),
    .out_eof      (out_eof),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .locked       (locked),
    .overflow_cnt (overflow_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    else
      passes++;
  endtask

  function automatic bit chance(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic modelReset();
    m_state  = SEARCH;
    m_idx    = 0;
    m_anchor = 0;
    m_goods  = 0;
    m_misses = 0;
    m_ovf    = 0;
    m_q.delete();
  endtask

  // Advance the reference by one clock edge with the given inputs
  task automatic modelStep(input logic [15:0] w, input logic vld, input logic rdy);
    bit          do_push;
    bit          do_pop;
    int          slot;
    fifo_entry_t e;
    do_push = 0;
    do_pop  = (m_q.size() != 0) && rdy;
    e       = '0;
    if (vld) begin
      slot = (m_idx - m_anchor) % (FRAME_LEN + 1);
      if (m_state == SEARCH) begin
        if (w == SYNC) begin
          m_anchor = m_idx;
          m_goods  = 1;
          m_misses = 0;
          m_state  = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        end
      end else if (m_state == VERIFY) begin
        if (slot == 0) begin
          if (w == SYNC) begin
            m_goods++;
            if (m_goods >= LOCK_CNT) begin
              m_state  = LOCKED;
              m_misses = 0;
            end
          end else begin
            m_state = SEARCH;
          end
        end
      end else begin
        if (slot == 0) begin
          if (w == SYNC) m_misses = 0;
          else begin
            m_misses++;
            if (m_misses >= LOSS_CNT) m_state = SEARCH;
          end
        end else begin
          do_push = 1;
          e.data  = w;
          e.sof   = (slot == 1);
          e.eof   = (slot == FRAME_LEN);
        end
      end
      m_idx++;
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else if (m_ovf < 255) m_ovf++;
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      checkOutput("out_data", out_data, m_q[0].data);
      checkOutput("out_sof", out_sof, m_q[0].sof);
      checkOutput("out_eof", out_eof, m_q[0].eof);
    end
    checkOutput("locked", locked, m_state == LOCKED);
    checkOutput("overflow_cnt", overflow_cnt, m_ovf);
  endtask

  // One clock: check outputs, drive new inputs, advance the model
  task automatic applyStimulus(input logic [15:0] w, input logic vld, input logic rdy);
    @(negedge clk_out);
    checkAll();
    in_data   = w;
    in_valid  = vld;
    out_ready = rdy;
    modelStep(w, vld, rdy);
  endtask

  task automatic sendWord(input logic [15:0] w, input int vpct, input int rpct);
    while (!chance(vpct)) applyStimulus(16'($urandom), 1'b0, chance(rpct));
    applyStimulus(w, 1'b1, chance(rpct));
  endtask

  task automatic sendFrame(input logic [15:0] sync_w, input bit rand_payload, input int vpct, input int rpct);
    sendWord(sync_w, vpct, rpct);
    for (int i = 1; i <= FRAME_LEN; i++)
      sendWord(rand_payload ? 16'($urandom) : 16'(i), vpct, rpct);
  endtask

  task automatic doReset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_sof", out_sof, 0);
    checkOutput("rst_out_eof", out_eof, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_overflow", overflow_cnt, 0);
    modelReset();
    @(negedge clk_out);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    modelReset();
    doReset();

    $display("[TB] lock on counting frames");
    for (int f = 0; f < 4; f++) sendFrame(SYNC, 1'b0, 100, 100);

    $display("[TB] single and double sync corruption");
    sendFrame(BAD, 1'b0, 100, 100);
    sendFrame(SYNC, 1'b0, 100, 100);
    sendFrame(BAD, 1'b0, 100, 100);
    sendFrame(BAD, 1'b0, 100, 100);
    for (int f = 0; f < 4; f++) sendFrame(SYNC, 1'b0, 100, 100);

    $display("[TB] stalled consumer");
    sendFrame(SYNC, 1'b0, 100, 0);
    sendFrame(SYNC, 1'b0, 100, 0);
    sendFrame(SYNC, 1'b0, 100, 100);

    $display("[TB] bad spacing while verifying");
    for (int f = 0; f < 2; f++) sendFrame(BAD, 1'b0, 100, 100);
    applyStimulus(BAD, 1'b1, 1'b1);
    applyStimulus(SYNC, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) applyStimulus(16'(i), 1'b1, 1'b1);
    applyStimulus(SYNC, 1'b1, 1'b1);
    for (int i = 6; i <= 8; i++) applyStimulus(16'(i), 1'b1, 1'b1);
    applyStimulus(16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(16'h0101 * 16'(i), 1'b1, 1'b1);

    $display("[TB] gapped input");
    for (int f = 0; f < 5; f++) sendFrame(SYNC, 1'b0, 50, 100);

    $display("[TB] overflow saturation");
    for (int f = 0; f < 40; f++) sendFrame(SYNC, 1'b1, 100, 0);
    applyStimulus(16'h0, 1'b0, 1'b0);
    checkOutput("ovf_saturated", overflow_cnt, 255);
    for (int i = 0; i < 6; i++) applyStimulus(16'h0, 1'b0, 1'b1);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 4; i++) applyStimulus(16'h0, 1'b0, 1'b1);
    applyStimulus(SYNC, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) applyStimulus(16'(i), 1'b1, 1'b0);
    applyStimulus(16'h0, 1'b0, 1'b0);
    checkOutput("pre_rst_valid", out_valid, 1);
    doReset();
    for (int f = 0; f < 4; f++) sendFrame(SYNC, 1'b0, 100, 100);

    $display("[TB] random traffic");
    for (int f = 0; f < 40; f++)
      sendFrame(chance(12) ? 16'($urandom) : SYNC, 1'b1, 70, 60);
    for (int i = 0; i < 8; i++) applyStimulus(16'h0, 1'b0, 1'b1);
    applyStimulus(16'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
